// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter: NREQ requesters share one registered bank write port,
// with bounded lock bursts of up to MAXLOCK consecutive grants to one owner.
module reg_wr_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 3,
    parameter int NREQ    = 4,
    parameter int MAXLOCK = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = $clog2(MAXLOCK + 1);

    localparam logic [0:0] StArb  = 1'b0;
    localparam logic [0:0] StLock = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    logic            do_arb;
    logic [PW-1:0]   sel;

    // Rotating priority scan starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        do_arb    = 1'b1;
        sel       = win;

        // A locked owner keeps the bank only while it asks to; otherwise fall through
        // to normal arbitration in this same cycle.
        if (state_q == StLock) begin
            state_d = StArb;
            if (req[owner_q] && lock[owner_q] && (int'(cnt_q) < MAXLOCK)) begin
                do_arb = 1'b0;
                sel    = owner_q;
                cnt_d  = cnt_q + 1'b1;
                if (int'(cnt_q) + 1 < MAXLOCK) begin
                    state_d = StLock;
                end
            end
        end

        if (do_arb && found) begin
            ptr_d = PW'((int'(win) + 1) % NREQ);
            if (lock[win] && (MAXLOCK > 1)) begin
                state_d = StLock;
                owner_d = win;
                cnt_d   = LW'(1);
            end
        end

        if (!do_arb || found) begin
            gnt_d[sel] = 1'b1;
            wr_en_d    = 1'b1;
            wr_addr_d  = addr[int'(sel)*AW +: AW];
            wr_data_d  = wdata[int'(sel)*DW +: DW];
        end

        busy_d = (state_d == StLock);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= StArb;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus randomized traffic
// compared against a grant-counting reference model.
module tb_reg_wr_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 3;
    localparam int NREQ    = 4;
    localparam int MAXLOCK = 4;
    localparam int BOUND   = (NREQ - 1) * MAXLOCK + 1;

    logic               CLK = 1'b0;
    logic               RSTn;
    logic [NREQ-1:0]    req, lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: next-scan start, current lock owner and its grant count.
    int              m_ptr, m_owner, m_cnt;
    bit              m_locked;
    logic [NREQ-1:0] e_gnt;
    logic            e_wr_en;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_data;
    logic            e_busy;

    reg_wr_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ), .MAXLOCK(MAXLOCK)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .req     (req),
        .lock    (lock),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
        e_gnt = '0; e_wr_en = 0; e_addr = '0; e_data = '0; e_busy = 0;
    endtask

    task automatic model_step();
        int w;
        w = -1;
        if (m_locked && req[m_owner] && lock[m_owner]) begin
            w = m_owner;
            m_cnt++;
            if (m_cnt == MAXLOCK) m_locked = 0;
        end else begin
            m_locked = 0;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            if (w >= 0) begin
                m_ptr = (w + 1) % NREQ;
                if (lock[w] && MAXLOCK > 1) begin
                    m_locked = 1; m_owner = w; m_cnt = 1;
                end
            end
        end
        e_gnt   = '0;
        e_wr_en = (w >= 0);
        if (w >= 0) begin
            e_gnt[w] = 1'b1;
            e_addr   = addr[w*AW +: AW];
            e_data   = wdata[w*DW +: DW];
        end
        e_busy = m_locked;
    endtask

    // Idle requesters present X on addr/wdata; it must never reach the outputs.
    task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
        req  = r;
        lock = l;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW]  = r[i] ? AW'($urandom) : 'x;
            wdata[i*DW +: DW] = r[i] ? DW'($urandom) : 'x;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #2 RSTn = 1'b0;
        model_reset();
        req = '0; lock = '0;
        #3 RSTn = 1'b1;
    endtask

    task automatic test_reset();
        drive(4'b1111, 4'b0000);
        tick();
        tick();
        #2 RSTn = 1'b0;
        #1;
        if ({gnt, wr_en, wr_addr, wr_data, busy} !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0", {gnt, wr_en, wr_addr, wr_data, busy});
        end
        checks++;
        model_reset();
        #2 RSTn = 1'b1;
        drive(4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({gnt, wr_en, wr_addr, wr_data, busy} !== '0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h required 0", i,
                         {gnt, wr_en, wr_addr, wr_data, busy});
            end
            checks++;
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 4'b0000);
            tick();
            exp_g = '0;
            exp_g[i % NREQ] = 1'b1;
            if (gnt !== exp_g || wr_en !== 1'b1) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: got gnt=%b wr_en=%b required gnt=%b wr_en=1",
                         i, gnt, wr_en, exp_g);
            end
            checks++;
            if ({gnt, wr_en, wr_addr, wr_data, busy} !== {e_gnt, e_wr_en, e_addr, e_data, e_busy}) begin
                errors++;
                $display("FAIL rr_model[%0d]: got %h required %h", i,
                         {gnt, wr_en, wr_addr, wr_data, busy}, {e_gnt, e_wr_en, e_addr, e_data, e_busy});
            end
            checks++;
        end
    endtask

    task automatic test_sparse();
        logic [NREQ-1:0] exp_g;
        logic [AW-1:0]   exp_a;
        logic [DW-1:0]   last_data;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0101, 4'b0000);
            exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            exp_a = (i % 2 == 0) ? addr[0 +: AW] : addr[2*AW +: AW];
            last_data = wdata[2*DW +: DW];
            tick();
            if (gnt !== exp_g || wr_addr !== exp_a) begin
                errors++;
                $display("FAIL sparse[%0d]: got gnt=%b addr=%0d required gnt=%b addr=%0d",
                         i, gnt, wr_addr, exp_g, exp_a);
            end
            checks++;
        end
        drive(4'b0000, 4'b0000);
        tick();
        if (wr_en !== 1'b0 || gnt !== '0 || wr_data !== last_data) begin
            errors++;
            $display("FAIL sparse_idle: got wr_en=%b gnt=%b data=%h required 0 0 %h",
                     wr_en, gnt, wr_data, last_data);
        end
        checks++;
    endtask

    task automatic test_lock_bound();
        logic [NREQ-1:0] exp_g [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        logic            exp_b [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        drive(4'b0010, 4'b0000);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(4'b1101, 4'b0100);
            tick();
            if (gnt !== exp_g[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL lock_bound[%0d]: got gnt=%b busy=%b required gnt=%b busy=%b",
                         i, gnt, busy, exp_g[i], exp_b[i]);
            end
            checks++;
            if ({gnt, wr_en, wr_addr, wr_data, busy} !== {e_gnt, e_wr_en, e_addr, e_data, e_busy}) begin
                errors++;
                $display("FAIL lock_model[%0d]: got %h required %h", i,
                         {gnt, wr_en, wr_addr, wr_data, busy}, {e_gnt, e_wr_en, e_addr, e_data, e_busy});
            end
            checks++;
        end
    endtask

    task automatic test_early_unlock();
        do_reset();
        drive(4'b0010, 4'b0000);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(4'b1100, 4'b0100);
            tick();
            if (gnt !== 4'b0100 || busy !== 1'b1) begin
                errors++;
                $display("FAIL early_lock[%0d]: got gnt=%b busy=%b required gnt=0100 busy=1",
                         i, gnt, busy);
            end
            checks++;
        end
        drive(4'b1100, 4'b0000);
        tick();
        if (gnt !== 4'b1000 || busy !== 1'b0 || wr_en !== 1'b1 || wr_addr !== e_addr) begin
            errors++;
            $display("FAIL early_unlock: got gnt=%b busy=%b wr_en=%b required gnt=1000 busy=0 wr_en=1",
                     gnt, busy, wr_en);
        end
        checks++;
    endtask

    task automatic test_reset_during_lock();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0100, 4'b0100);
            tick();
        end
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rdl_busy: got busy=%b required 1", busy);
        end
        checks++;
        #2 RSTn = 1'b0;
        #1;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL rdl_async: got busy=%b gnt=%b required 0 0", busy, gnt);
        end
        checks++;
        model_reset();
        #2 RSTn = 1'b1;
        drive(4'b0101, 4'b0000);
        tick();
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rdl_first: got gnt=%b required 0001", gnt);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(NREQ'($urandom), NREQ'($urandom) & NREQ'($urandom));
            tick();
            if ({gnt, wr_en, wr_addr, wr_data, busy} !== {e_gnt, e_wr_en, e_addr, e_data, e_busy}) begin
                errors++;
                $display("FAIL random[%0d]: got %h required %h", i,
                         {gnt, wr_en, wr_addr, wr_data, busy}, {e_gnt, e_wr_en, e_addr, e_data, e_busy});
            end
            checks++;
        end
    endtask

    task automatic test_starvation();
        int wt [NREQ];
        do_reset();
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
        for (int c = 0; c < 200; c++) begin
            drive(4'b1111, NREQ'($urandom));
            tick();
            if ({gnt, wr_en, wr_addr, wr_data, busy} !== {e_gnt, e_wr_en, e_addr, e_data, e_busy}) begin
                errors++;
                $display("FAIL starve_model[%0d]: got %h required %h", c,
                         {gnt, wr_en, wr_addr, wr_data, busy}, {e_gnt, e_wr_en, e_addr, e_data, e_busy});
            end
            checks++;
            for (int i = 0; i < NREQ; i++) begin
                wt[i]++;
                if (gnt[i]) begin
                    if (wt[i] > BOUND) begin
                        errors++;
                        $display("FAIL starve[%0d]: got wait=%0d required <=%0d", i, wt[i], BOUND);
                    end
                    checks++;
                    wt[i] = 0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (wt[i] > BOUND) begin
                errors++;
                $display("FAIL starve_end[%0d]: got wait=%0d required <=%0d", i, wt[i], BOUND);
            end
            checks++;
        end
    endtask

    initial begin
        RSTn = 1'b0; req = '0; lock = '0; addr = '0; wdata = '0;
        model_reset();
        #12 RSTn = 1'b1;
        test_reset();
        test_round_robin();
        test_sparse();
        test_lock_bound();
        test_early_unlock();
        test_reset_during_lock();
        test_random();
        test_starvation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
